fft_bitrev_reorder: RTL and testbench
=====================================

# fft_bitrev_reorder

Output reordering buffer that sits directly downstream of the last radix-2 SDF delay/butterfly stage of the FFT pipeline. It accepts the complex stream that stage emits, one sample per cycle in bit-reversed frequency order, with 8-bit real and 8-bit imaginary parts. It re-emits each N-point frame in natural order (X[0]..X[N-1]). A two-bank ping-pong memory lets one frame be written while the previous one is read out, and an output valid/ready handshake lets the consumer apply backpressure.

## Interface
- N, 8: points per frame; power of two, ≥ 4.
- LOG2N, 3: log2(N); width of the address counters.
- W, 8: width of each real/imaginary component. Matches n/2 of the upstream stage.

- clk  input  1  clock; all state updates on rising edge.
- clear  input  1  reset; asynchronous, active-low.
- in_valid  input  1  in_r/in_im carry a sample this cycle.
- in_r  input  W  real part from upstream stage (y_r).
- in_im  input  W  imaginary part from upstream stage (y_im).
- in_ready  output  1  buffer can accept a sample this cycle.
- out_valid  output  1  out_r/out_im hold a valid natural-order sample.
- out_ready  input  1  consumer accepts the current output sample.
- out_r  output  W  real part, natural order.
- out_im  output  W  imaginary part, natural order.
- out_index  output  LOG2N  frequency index of the current output sample.
- out_last  output  1  current output is index N-1 of its frame.
- overflow  output  1  sticky; a sample arrived while in_ready was low.

## Operation
- Storage: mem[2][N] of 2W bits, {re, im}, built from flops. All entries reset to 0.
- Write-side registers:
  - wr_bank (1 bit) selects the bank being filled.
  - wr_cnt (LOG2N bits) counts arrivals within the frame.
  - full[1:0] marks a bank as completely written.
- Read-side registers:
  - rd_bank (1 bit) selects the bank being drained.
  - rd_cnt (LOG2N bits) is the natural-order read index.
- in_ready = ~full[wr_bank]. This is a combinational function of registers.
- Write accept (in_valid & in_ready):
  - mem[wr_bank][bitrev(wr_cnt)] <= {in_r, in_im}. bitrev reverses all LOG2N bits.
  - wr_cnt increments.
  - When wr_cnt == N-1: full[wr_bank] <= 1, wr_bank toggles, wr_cnt wraps to 0.
- Dropped write (in_valid & ~in_ready):
  - Memory and counters are unchanged.
  - overflow <= 1, and it stays set until clear.
- out_valid = full[rd_bank].
- out_{r,im} = mem[rd_bank][rd_cnt]. This is an unregistered read through registered pointers.
- out_index = rd_cnt.
- out_last = out_valid & (rd_cnt == N-1).
- Read accept (out_valid & out_ready):
  - rd_cnt increments.
  - On out_last: full[rd_bank] <= 0, rd_bank toggles, rd_cnt wraps to 0.
- out_ready while out_valid is low has no effect.
- Simultaneous write-complete and read-complete always target different banks. A bank can only be written while not full and only read while full. Both updates apply in the same cycle.
- Bank state per bank: FILLING (full=0, selected by wr_bank) → FULL (full=1) → DRAINING (selected by rd_bank) → back to FILLING after its last read.
- Output data while out_valid=0 is don't-care for the consumer. Memory contents persist, so it is deterministic.

## Timing
- Reset (clear low, asynchronous) sets:
  - wr_bank, rd_bank, wr_cnt, rd_cnt, full and overflow to 0, and all memory to 0.
  - Outputs therefore read: in_ready=1, out_valid=0, out_last=0, out_index=0, out_r=out_im=0.
- clear de-assertion is synchronous to clk upstream. The first write can occur on the first rising edge with clear high.
- Latency: out_valid rises the cycle after the edge that accepts the N-th sample of a frame, and out_index=0 on that cycle.
- Throughput: 1 sample/cycle each side with out_ready held high. Continuous input never drops in_ready, since a frame drains in exactly N cycles.
- in_ready falls the cycle after the edge on which both banks become full. It rises the cycle after the edge accepting out_last.
- Reset mid-frame discards all partial and full frames. The next accepted sample is arrival 0 of a new frame in bank 0.

## Test plan
- Reset: hold clear low for 3 cycles with random inputs → in_ready=1, out_valid=0, overflow=0, out_r=out_im=0 throughout.
- Single frame, N=8:
  - Stimulus: arrival k carries in_r=bitrev(k), in_im=8'hF0|bitrev(k); out_ready=1.
  - Required: out_valid rises 1 cycle after the 8th accept. Outputs are out_r=0..7 and out_im=F0..F7 on consecutive cycles, out_index matches out_r, and out_last is asserted only on index 7.
- Back-to-back: 4 frames with in_valid held high and out_ready=1 → in_ready never low, 32 consecutive natural-order outputs, overflow=0.
- Backpressure:
  - Hold out_ready=0 and feed 16 samples → in_ready low from the next cycle.
  - Drive a 17th sample → it is dropped and overflow=1.
  - Raise out_ready → 16 correct outputs in frame order, in_ready high again after the first frame's out_last. overflow remains 1.
- Random out_ready: toggle ~50% across 6 continuous frames → every accepted output matches a reference model, with no duplicates or skips.
- Reset mid-operation: assert clear after 5 writes of frame 2 while frame 1 is half read → all state clears immediately. The next 8-sample frame emerges correctly starting at index 0.

Source files
------------

// File: rtl/fft_bitrev_reorder.sv
// ---------------------------------------------------------------------------
// fft_bitrev_reorder
//
// Output reordering buffer for the last radix-2 SDF stage of the FFT
// pipeline. Complex samples arrive one per cycle in bit-reversed frequency
// order and leave in natural order X[0]..X[N-1]. Two flop-based banks
// ping-pong so that one frame fills while the previous frame drains.
//
// Ports
//   clk        clock, all state updates on rising edge
//   clear      asynchronous active-low reset
//   in_valid   in_r/in_im carry a sample this cycle
//   in_r/in_im real/imaginary part from upstream stage
//   in_ready   buffer can accept a sample this cycle
//   out_valid  out_r/out_im hold a valid natural-order sample
//   out_ready  consumer accepts the current output sample
//   out_r/im   real/imaginary part, natural order
//   out_index  frequency index of the current output sample
//   out_last   current output is index N-1 of its frame
//   overflow   sticky: a sample arrived while in_ready was low
// ---------------------------------------------------------------------------
module fft_bitrev_reorder #(
   parameter int unsigned N     = 8,
   parameter int unsigned LOG2N = 3,
   parameter int unsigned W     = 8
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             in_valid,
   input  logic [W-1:0]     in_r,
   input  logic [W-1:0]     in_im,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_r,
   output logic [W-1:0]     out_im,
   output logic [LOG2N-1:0] out_index,
   output logic             out_last,
   output logic             overflow
);

   localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

   // Storage: two banks of N complex words {re, im}
   logic [2*W-1:0]   mem [2][N];

   // Write side
   logic             wr_bank;
   logic [LOG2N-1:0] wr_cnt;
   logic [1:0]       full;

   // Read side
   logic             rd_bank;
   logic [LOG2N-1:0] rd_cnt;

   logic             wr_acc;
   logic             rd_acc;
   logic             wr_done;
   logic             rd_done;
   logic [LOG2N-1:0] wr_addr;
   logic [1:0]       full_nxt;
   logic [2*W-1:0]   rd_word;

   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
      logic [LOG2N-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < LOG2N; i++) begin
         r[i] = a[LOG2N-1-i];
      end
      return r;
   endfunction

   // ------------------------------------------------------------------------
   // Handshake and address decode
   // ------------------------------------------------------------------------
   always_comb begin
      in_ready  = ~full[wr_bank];
      out_valid = full[rd_bank];
      wr_acc    = in_valid & in_ready;
      rd_acc    = out_valid & out_ready;
      wr_done   = wr_acc & (wr_cnt == LAST);
      rd_done   = rd_acc & (rd_cnt == LAST);
      wr_addr   = bitrev(wr_cnt);
   end

   // A completing write and a completing read always refer to different
   // banks (one is filling, the other is full), so both updates can be
   // merged without priority.
   always_comb begin
      full_nxt = full;
      if (wr_done) begin
         full_nxt[wr_bank] = 1'b1;
      end
      if (rd_done) begin
         full_nxt[rd_bank] = 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Unregistered read through registered pointers
   // ------------------------------------------------------------------------
   always_comb begin
      rd_word   = mem[rd_bank][rd_cnt];
      out_r     = rd_word[2*W-1:W];
      out_im    = rd_word[W-1:0];
      out_index = rd_cnt;
      out_last  = out_valid & (rd_cnt == LAST);
   end

   // ------------------------------------------------------------------------
   // Memory
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         for (int unsigned b = 0; b < 2; b++) begin
            for (int unsigned e = 0; e < N; e++) begin
               mem[b][e] <= '0;
            end
         end
      end else if (wr_acc) begin
         mem[wr_bank][wr_addr] <= {in_r, in_im};
      end
   end

   // ------------------------------------------------------------------------
   // Pointers, bank flags and overflow
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         wr_bank  <= 1'b0;
         wr_cnt   <= '0;
         rd_bank  <= 1'b0;
         rd_cnt   <= '0;
         full     <= '0;
         overflow <= 1'b0;
      end else begin
         // Counters are LOG2N bits wide and N is a power of two, so the
         // increment past N-1 wraps to 0 on its own.
         if (wr_acc) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_done) begin
               wr_bank <= ~wr_bank;
            end
         end
         if (rd_acc) begin
            rd_cnt <= rd_cnt + 1'b1;
            if (rd_done) begin
               rd_bank <= ~rd_bank;
            end
         end
         full <= full_nxt;
         if (in_valid & ~in_ready) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
module tb_fft_bitrev_reorder;
   localparam int N     = 8;
   localparam int LOG2N = 3;
   localparam int W     = 8;

   logic             clk = 1'b0;
   logic             clear = 1'b0;
   logic             in_valid = 1'b0;
   logic [W-1:0]     in_r = '0;
   logic [W-1:0]     in_im = '0;
   logic             in_ready;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [W-1:0]     out_r;
   logic [W-1:0]     out_im;
   logic [LOG2N-1:0] out_index;
   logic             out_last;
   logic             overflow;

   fft_bitrev_reorder #(.N(N), .LOG2N(LOG2N), .W(W)) dut (
      .clk(clk), .clear(clear),
      .in_valid(in_valid), .in_r(in_r), .in_im(in_im), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_r(out_r), .out_im(out_im), .out_index(out_index),
      .out_last(out_last), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Reference model: queue of natural-order samples of completed frames
   // ------------------------------------------------------------------------
   logic [15:0] q[$];
   logic [15:0] part[N];
   int          pcnt = 0;
   bit          m_ovf = 0;

   function automatic int brev(input int k);
      int r = 0;
      int v = k;
      for (int b = 0; b < LOG2N; b++) begin
         r = r * 2 + (v % 2);
         v = v / 2;
      end
      return r;
   endfunction

   function automatic int m_nfull();
      return (q.size() + N - 1) / N;
   endfunction

   function automatic bit m_rdy();
      return m_nfull() < 2;
   endfunction

   always @(posedge clk or negedge clear) begin
      if (!clear) begin
         q.delete();
         pcnt = 0;
         m_ovf = 0;
      end else begin
         bit wa;
         bit ra;
         wa = in_valid && m_rdy();
         ra = out_ready && (q.size() > 0);
         if (in_valid && !m_rdy()) m_ovf = 1;
         if (ra) void'(q.pop_front());
         if (wa) begin
            part[pcnt] = {in_r, in_im};
            pcnt++;
            if (pcnt == N) begin
               // natural index i holds the arrival whose position is bitrev(i)
               for (int i = 0; i < N; i++) q.push_back(part[brev(i)]);
               pcnt = 0;
            end
         end
      end
   end

   // Per-cycle comparison, away from the active edge
   always @(negedge clk) begin
      if (!clear) begin
         chk("rst_in_ready", in_ready, 1);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_overflow", overflow, 0);
         chk("rst_out_last", out_last, 0);
         chk("rst_out_index", out_index, 0);
         chk("rst_out_data", {out_r, out_im}, 0);
      end else begin
         int idx;
         idx = (N - (q.size() % N)) % N;
         chk("in_ready", in_ready, m_rdy());
         chk("out_valid", out_valid, q.size() > 0);
         chk("overflow", overflow, m_ovf);
         chk("out_index", out_index, idx);
         chk("out_last", out_last, (q.size() > 0) && (idx == N - 1));
         if (q.size() > 0) chk("out_data", {out_r, out_im}, q[0]);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   initial begin
      int acc;
      int n;

      // Reset with random inputs
      for (int i = 0; i < 3; i++) begin
         in_valid  = 1'($urandom);
         in_r      = 8'($urandom);
         in_im     = 8'($urandom);
         out_ready = 1'($urandom);
         cyc();
      end
      in_valid = 0;
      clear = 1;

      // Single frame with hand-computed expectations
      out_ready = 1;
      for (int k = 0; k < N; k++) begin
         in_valid = 1;
         in_r  = 8'(brev(k));
         in_im = 8'(8'hF0 | brev(k));
         cyc();
      end
      in_valid = 0;
      chk("sf_latency_valid", out_valid, 1);
      for (int i = 0; i < N; i++) begin
         chk("sf_out_r", out_r, i);
         chk("sf_out_im", out_im, 8'hF0 | i);
         chk("sf_out_index", out_index, i);
         chk("sf_out_last", out_last, i == 7);
         cyc();
      end
      chk("sf_done_valid", out_valid, 0);

      // Back-to-back 4 frames
      for (int k = 0; k < 4 * N; k++) begin
         in_valid = 1;
         in_r  = 8'($urandom);
         in_im = 8'($urandom);
         cyc();
      end
      in_valid = 0;
      repeat (2 * N) cyc();
      chk("b2b_overflow", overflow, 0);

      // Backpressure
      out_ready = 0;
      for (int k = 0; k < 2 * N; k++) begin
         in_valid = 1;
         in_r  = 8'($urandom);
         in_im = 8'($urandom);
         cyc();
      end
      chk("bp_in_ready_low", in_ready, 0);
      in_r = 8'hAA;
      in_im = 8'h55;
      cyc();
      in_valid = 0;
      chk("bp_overflow_set", overflow, 1);
      out_ready = 1;
      repeat (N - 1) cyc();
      chk("bp_last_first_frame", out_last, 1);
      cyc();
      chk("bp_in_ready_high", in_ready, 1);
      repeat (N + 2) cyc();
      chk("bp_overflow_sticky", overflow, 1);
      chk("bp_drained", out_valid, 0);

      // Random out_ready over 6 continuous frames
      acc = 0;
      n = 0;
      while (acc < 6 * N && n < 2000) begin
         out_ready = 1'($urandom);
         in_valid  = m_rdy() && ($urandom_range(0, 9) < 9);
         in_r  = 8'($urandom);
         in_im = 8'($urandom);
         if (in_valid) acc++;
         cyc();
         n++;
      end
      in_valid = 0;
      chk("rand_feed_accepted", acc, 6 * N);
      n = 0;
      while (q.size() > 0 && n < 500) begin
         out_ready = 1'($urandom);
         cyc();
         n++;
      end
      out_ready = 0;
      chk("rand_drained", out_valid, 0);

      // Reset in mid-operation
      @(posedge clk);
      #2;
      clear = 0;
      cyc();
      clear = 1;
      for (int k = 0; k < N; k++) begin
         in_valid = 1;
         in_r  = 8'($urandom);
         in_im = 8'($urandom);
         cyc();
      end
      out_ready = 1;
      for (int k = 0; k < 5; k++) begin
         in_r  = 8'($urandom);
         in_im = 8'($urandom);
         cyc();
      end
      in_valid = 0;
      clear = 0;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_out_index", out_index, 0);
      cyc();
      clear = 1;
      for (int k = 0; k < N; k++) begin
         in_valid = 1;
         in_r  = 8'(brev(k));
         in_im = 8'(8'h30 | brev(k));
         cyc();
      end
      in_valid = 0;
      chk("post_rst_valid", out_valid, 1);
      chk("post_rst_index0", out_index, 0);
      chk("post_rst_data0", {out_r, out_im}, 16'h0030);
      repeat (N + 2) cyc();
      chk("post_rst_drained", out_valid, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
